tx_resp_arbiter: RTL and testbench

Shares the single UART transmitter between three response producers: register-file read data, ALU results, and command-decoder error codes. Each producer has a one-entry holding register, and a round-robin arbiter picks one pending response at a time. It serializes the response into bytes and runs the TX_VLD/BUSY handshake with the UART TX. It sits between the register file, the ALU, the command-decoding FSM and the UART transmitter, and supervises the transmitter with a BUSY timeout.

---
 rtl/tx_resp_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_tx_resp_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the register-file,
// ALU and error-code response producers, with a BUSY-rise watchdog.

module tx_resp_slot #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  input  logic         i_grant,
  input  logic [W-1:0] i_d,
  output logic         o_pend,
  output logic [W-1:0] o_q,
  output logic         o_ovr
);
  logic         r_pend;
  logic [W-1:0] r_q;

  // A strobe on the grant edge refills the slot instead of overrunning it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pend <= 1'b0;
      r_q    <= '0;
    end else if (i_vld && (!r_pend || i_grant)) begin
      r_q    <= i_d;
      r_pend <= 1'b1;
    end else if (i_grant) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_q    = r_q;
  assign o_ovr  = i_vld & r_pend & ~i_grant;
endmodule

module tx_resp_arbiter #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  Rd_D,
  input  logic        Rd_D_VLD,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_VLD,
  input  logic [7:0]  ERR_CODE,
  input  logic        ERR_VLD,
  input  logic        BUSY,
  input  logic        CLR_FLAGS,
  output logic        TX_VLD,
  output logic [7:0]  TX_IN,
  output logic [2:0]  OVERRUN,
  output logic        TIMEOUT,
  output logic        IDLE
);
  localparam int         NSRC    = 3;
  localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t r_state, w_state_nxt;

  logic                       r_tx_vld;
  logic [7:0]                 r_tx_in;
  logic [7:0]                 r_cnt;
  logic [15:0]                r_shift;
  logic                       r_rem;
  logic [1:0]                 r_ptr;
  logic [2:0]                 r_ovr;
  logic                       r_to;

  logic [NSRC-1:0][15:0]      w_din;
  logic [NSRC-1:0][15:0]      w_q;
  logic [NSRC-1:0]            w_strb;
  logic [NSRC-1:0]            w_pend;
  logic [NSRC-1:0]            w_grant;
  logic [NSRC-1:0]            w_ovr_set;
  logic                       w_found;
  logic [1:0]                 w_win;
  logic                       w_load, w_send, w_cnt_inc, w_to_set, w_shift;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign w_din  = {{8'h00, ERR_CODE}, ALU_OUT, {8'h00, Rd_D}};
  assign w_strb = {ERR_VLD, ALU_VLD, Rd_D_VLD};

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_slot
      tx_resp_slot #(.W(16)) u_slot (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_vld   (w_strb[g]),
        .i_grant (w_grant[g]),
        .i_d     (w_din[g]),
        .o_pend  (w_pend[g]),
        .o_q     (w_q[g]),
        .o_ovr   (w_ovr_set[g])
      );
    end
  endgenerate

  // First pending source at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 0; k < NSRC; k++) begin
      if (!w_found && w_pend[rr_idx(r_ptr, 2'(k))]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_ptr, 2'(k));
      end
    end
  end

  assign w_grant = w_load ? (3'b001 << w_win) : 3'b000;

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_send      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_to_set    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_send      = 1'b1;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (BUSY) begin
          w_state_nxt = S_WAIT_LO;
        end else if (r_cnt == TO_LAST) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!BUSY) begin
          if (r_rem) begin
            w_shift     = 1'b1;
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_tx_vld <= 1'b0;
      r_tx_in  <= 8'h00;
      r_cnt    <= 8'h00;
      r_shift  <= 16'h0000;
      r_rem    <= 1'b0;
      r_ptr    <= 2'd0;
      r_ovr    <= 3'b000;
      r_to     <= 1'b0;
    end else begin
      r_tx_vld <= w_send;
      if (w_send) begin
        r_tx_in <= r_shift[7:0];
        r_cnt   <= 8'h00;
      end else if (w_cnt_inc) begin
        r_cnt   <= r_cnt + 8'h01;
      end
      if (w_load) begin
        r_shift <= w_q[w_win];
        r_rem   <= (w_win == 2'd1);
        r_ptr   <= rr_idx(w_win, 2'd1);
      end else if (w_shift) begin
        r_shift <= {8'h00, r_shift[15:8]};
        r_rem   <= 1'b0;
      end else if (w_to_set) begin
        r_rem   <= 1'b0;
      end
      // Set beats clear when both land on the same edge.
      r_ovr <= (CLR_FLAGS ? 3'b000 : r_ovr) | w_ovr_set;
      r_to  <= (CLR_FLAGS ? 1'b0 : r_to) | w_to_set;
    end
  end

  assign TX_VLD  = r_tx_vld;
  assign TX_IN   = r_tx_in;
  assign OVERRUN = r_ovr;
  assign TIMEOUT = r_to;
  assign IDLE    = (r_state == S_IDLE) & ~|w_pend;
endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Randomized scoreboard bench for tx_resp_arbiter: a queue-based RR model predicts
// the byte stream, a UART model answers TX_VLD with BUSY, a monitor checks bytes.
`timescale 1ns/1ps
module tb_tx_resp_arbiter;
  localparam int TO = 16;

  logic        CLK = 1'b0, RST = 1'b0;
  logic [7:0]  Rd_D = '0, ERR_CODE = '0;
  logic [15:0] ALU_OUT = '0;
  logic        Rd_D_VLD = 0, ALU_VLD = 0, ERR_VLD = 0, BUSY = 0, CLR_FLAGS = 0;
  logic        TX_VLD, TIMEOUT, IDLE;
  logic [7:0]  TX_IN;
  logic [2:0]  OVERRUN;

  tx_resp_arbiter #(.BUSY_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .Rd_D(Rd_D), .Rd_D_VLD(Rd_D_VLD), .ALU_OUT(ALU_OUT),
    .ALU_VLD(ALU_VLD), .ERR_CODE(ERR_CODE), .ERR_VLD(ERR_VLD), .BUSY(BUSY),
    .CLR_FLAGS(CLR_FLAGS), .TX_VLD(TX_VLD), .TX_IN(TX_IN), .OVERRUN(OVERRUN),
    .TIMEOUT(TIMEOUT), .IDLE(IDLE)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic [7:0] expq[$];
  int vld_hist[$];
  int last_fall_cyc = 0, vld_gap = 0, n_tx = 0, to_rise_cyc = -1, batch_cyc = 0;
  logic prev_vld = 0, prev_to = 0;
  bit uart_en = 1;
  int force_len = 0;

  // reference model state
  int m_ptr = 0;
  logic [2:0] m_ovr = 0;
  logic m_to = 0;
  bit m_tomode = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (TX_VLD) begin
      n_tx++;
      vld_hist.push_back(cyc);
      vld_gap = cyc - last_fall_cyc;
      chk("tx_single_pulse", {31'd0, prev_vld}, 32'd0);
      if (expq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_tx: got byte %0h, none expected", TX_IN);
      end else begin
        chk("tx_byte", {24'd0, TX_IN}, {24'd0, expq.pop_front()});
      end
    end
    if (TIMEOUT && !prev_to) to_rise_cyc = cyc;
    prev_vld = TX_VLD;
    prev_to  = TIMEOUT;
  end

  // UART TX model: BUSY rises 1..3 cycles after the strobe, holds a few cycles
  initial begin
    forever begin
      @(negedge CLK);
      if (TX_VLD && uart_en) begin
        repeat ($urandom_range(3, 1)) @(negedge CLK);
        BUSY = 1'b1;
        repeat ((force_len != 0) ? force_len : $urandom_range(6, 1)) @(negedge CLK);
        BUSY = 1'b0;
        last_fall_cyc = cyc;
      end
    end
  end

  function automatic int pick(logic [2:0] p, int ptr);
    for (int k = 0; k < 3; k++) if (p[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  task automatic push_frame(int s, logic [15:0] d);
    expq.push_back(d[7:0]);
    if (s == 1 && !m_tomode) expq.push_back(d[15:8]);
  endtask

  task automatic drive(logic [2:0] m, logic [2:0][15:0] d, bit c);
    Rd_D_VLD = m[0]; Rd_D = d[0][7:0];
    ALU_VLD = m[1]; ALU_OUT = d[1];
    ERR_VLD = m[2]; ERR_CODE = d[2][7:0];
    CLR_FLAGS = c;
  endtask

  task automatic wait_idle(string nm);
    int t = 0;
    @(negedge CLK);
    while (!(IDLE && !BUSY && expq.size() == 0) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    repeat (2) @(negedge CLK);
    chk({nm, "_drain_in_time"}, {31'd0, (t < 3000)}, 32'd1);
  endtask

  // m1 strobes at edge N, m2 strobes at edge N+1 (the first grant edge)
  task automatic batch(string nm, logic [2:0] m1, logic [2:0][15:0] d1,
                       logic [2:0] m2, logic [2:0][15:0] d2, bit clr2);
    logic [2:0] pend;
    logic [2:0][15:0] hold;
    int w;
    pend = m1; hold = d1;
    w = pick(pend, m_ptr);
    push_frame(w, hold[w]);
    m_ptr = (w + 1) % 3;
    pend[w] = 1'b0;
    if (clr2) begin m_ovr = 0; m_to = 0; end
    for (int s = 0; s < 3; s++)
      if (m2[s]) begin
        if (pend[s]) m_ovr[s] = 1'b1;
        else begin pend[s] = 1'b1; hold[s] = d2[s]; end
      end
    while (pend != 0) begin
      w = pick(pend, m_ptr);
      push_frame(w, hold[w]);
      m_ptr = (w + 1) % 3;
      pend[w] = 1'b0;
    end
    @(negedge CLK); batch_cyc = cyc; drive(m1, d1, 0);
    @(negedge CLK); drive(m2, d2, clr2);
    @(negedge CLK); drive(3'b000, d2, 0);
    wait_idle(nm);
    chk({nm, "_overrun"}, {29'd0, OVERRUN}, {29'd0, m_ovr});
    chk({nm, "_timeout"}, {31'd0, TIMEOUT}, {31'd0, m_to});
    chk({nm, "_idle"}, {31'd0, IDLE}, 32'd1);
  endtask

  task automatic clr_flags();
    @(negedge CLK); CLR_FLAGS = 1'b1;
    @(negedge CLK); CLR_FLAGS = 1'b0;
    m_ovr = 0; m_to = 0;
    chk("clr_overrun", {29'd0, OVERRUN}, 32'd0);
    chk("clr_timeout", {31'd0, TIMEOUT}, 32'd0);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_txvld"}, {31'd0, TX_VLD}, 32'd0);
    chk({nm, "_txin"}, {24'd0, TX_IN}, 32'd0);
    chk({nm, "_overrun"}, {29'd0, OVERRUN}, 32'd0);
    chk({nm, "_timeout"}, {31'd0, TIMEOUT}, 32'd0);
    chk({nm, "_idle"}, {31'd0, IDLE}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    chk_reset("reset");
    RST = 1'b1;
    m_ptr = 0; m_ovr = 0; m_to = 0; m_tomode = 0;
    expq.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][15:0] d1, d2, z;
    logic [2:0] m1, m2;
    int h0, t;
    z = '0;
    repeat (3) @(negedge CLK);
    chk_reset("por");
    RST = 1'b1;

    // single register read and its latency
    d1 = '0; d1[0] = 16'h00A5;
    t = n_tx;
    batch("single_rd", 3'b001, d1, 3'b000, z, 0);
    chk("single_rd_count", n_tx - t, 1);
    chk("single_rd_latency", vld_hist[vld_hist.size()-1], batch_cyc + 3);

    // ALU byte order and inter-byte gap
    d1 = '0; d1[1] = 16'h1234;
    batch("alu_order", 3'b010, d1, 3'b000, z, 0);
    chk("alu_byte_gap", vld_gap, 2);

    // round robin from a fresh pointer, then from pointer 2
    do_reset();
    d1 = '0; d1[0] = 16'h0011; d1[1] = 16'hBBAA; d1[2] = 16'h0033;
    batch("rr_all", 3'b111, d1, 3'b000, z, 0);
    chk("frame_to_frame_gap", vld_gap, 3);
    d1 = '0; d1[1] = 16'h5566;
    batch("rr_alu_only", 3'b010, d1, 3'b000, z, 0);
    d1 = '0; d1[0] = 16'h0044; d1[2] = 16'h0077;
    batch("rr_src2_first", 3'b101, d1, 3'b000, z, 0);

    // overrun on source 1 while Rd is being served (pointer brought to 0)
    d1 = '0; d1[2] = 16'h00EE;
    batch("ptr_to_0", 3'b100, d1, 3'b000, z, 0);
    d1 = '0; d1[0] = 16'h0099; d1[1] = 16'h1111;
    d2 = '0; d2[1] = 16'h2222;
    batch("overrun", 3'b011, d1, 3'b010, d2, 0);
    clr_flags();
    batch("overrun_set_clr", 3'b011, d1, 3'b010, d2, 1);
    clr_flags();
    // strobe on the grant edge of the same source is a new entry
    d1 = '0; d1[1] = 16'hCAFE;
    d2 = '0; d2[1] = 16'hF00D;
    batch("grant_edge_refill", 3'b010, d1, 3'b010, d2, 0);

    // randomized batches
    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 3; s++) begin
        d1[s] = 16'($urandom);
        d2[s] = 16'($urandom);
      end
      m1 = 3'($urandom_range(7, 1));
      m2 = ($urandom_range(1, 0) != 0) ? 3'($urandom) : 3'b000;
      batch("rand", m1, d1, m2, d2, ($urandom_range(7, 0) == 0));
      if ($urandom_range(3, 0) == 0) clr_flags();
    end

    // BUSY timeout: ALU low byte aborts, ERR is still served
    d1 = '0; d1[0] = 16'h0001;
    batch("ptr_to_1", 3'b001, d1, 3'b000, z, 0);
    clr_flags();
    uart_en = 0; m_tomode = 1; m_to = 1;
    d1 = '0; d1[1] = 16'h1234; d1[2] = 16'h005A;
    h0 = vld_hist.size();
    to_rise_cyc = -1;
    batch("timeout", 3'b110, d1, 3'b000, z, 0);
    chk("timeout_delay", to_rise_cyc - vld_hist[h0], TO);
    uart_en = 1; m_tomode = 0;

    // reset in WAIT_LO of an ALU frame: no high byte afterwards
    force_len = 20;
    expq.push_back(8'hEF);
    @(negedge CLK); drive(3'b010, {16'h0, 16'hBEEF, 16'h0}, 0);
    @(negedge CLK); drive(3'b000, z, 0);
    t = 0;
    while (!BUSY && t < 50) begin @(negedge CLK); t++; end
    chk("rst_busy_seen", {31'd0, BUSY}, 32'd1);
    repeat (3) @(negedge CLK);
    chk("rst_lo_sent", expq.size(), 0);
    do_reset();
    repeat (40) @(negedge CLK);
    force_len = 0;
    chk("rst_idle_after", {31'd0, IDLE}, 32'd1);
    d1 = '0; d1[0] = 16'h0061; d1[1] = 16'h6362; d1[2] = 16'h0064;
    batch("rr_after_reset", 3'b111, d1, 3'b000, z, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
